// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pipe_pkg : shared types for the 5-stage MIPS pipeline control |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mips_pipe_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_use_detect : flags an ID source reading an in-flight load     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_uses_rt,
  input  logic     idex_memread,
  input  reg_idx_t idex_rt,
  output logic     hazard
);

  logic rs_match;
  logic rt_match;

  // $zero never carries a real dependency, so a load into it is ignored.
  assign rs_match = (idex_rt == id_rs);
  assign rt_match = id_uses_rt && (idex_rt == id_rt);
  assign hazard   = idex_memread && (idex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush sequencing for the 5-stage pipeline |
// | Optional stall counter with STALL_STATS_EN.  Rev 1.0               |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WCNT_W   = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_uses_rt,
  input  logic     idex_memread,
  input  reg_idx_t idex_rt,
  input  logic     ex_br_taken,
  input  logic     mem_req,
  input  logic     dmem_ready,
  output logic     pc_en,
  output logic     ifid_en,
  output logic     ifid_flush,
  output logic     idex_en,
  output logic     idex_flush,
  output logic     exmem_en,
  output logic     memwb_bubble,
  output logic     mem_timeout
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [WCNT_W-1:0] C_MAX_WAIT = WCNT_W'(MAX_WAIT);

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              mem_stall;
  logic              lu_hazard;

  load_use_detect u_lu (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .hazard       (lu_hazard)
  );

  assign mem_stall = (state_q != ERROR) && mem_req && !dmem_ready;
  assign wcnt_inc  = wcnt_q + WCNT_W'(1);

  // The counter is zero whenever the FSM sits in IDLE, so the first
  // stalled cycle (still in IDLE) counts as wait cycle one.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    case (state_q)
      IDLE, MEM_WAIT: begin
        if (mem_stall) begin
          wcnt_d  = wcnt_inc;
          state_d = (wcnt_inc >= C_MAX_WAIT) ? ERROR : MEM_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    mem_timeout  = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mem_stall || (state_q == ERROR)) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      mem_timeout  = (state_q == ERROR);
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  assign stall_cycles_d = pc_en ? stall_cycles_q : stall_cycles_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed self-checking bench                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_timeout}
  localparam logic [7:0] C_NORMAL = 8'b1101_0100;
  localparam logic [7:0] C_RESET  = 8'b0010_1010;
  localparam logic [7:0] C_STALL  = 8'b0000_0010;
  localparam logic [7:0] C_BRANCH = 8'b1111_1100;
  localparam logic [7:0] C_LDUSE  = 8'b0001_1100;
  localparam logic [7:0] C_ERROR  = 8'b0000_0011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, idex_memread, ex_br_taken, mem_req, dmem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic       memwb_bubble, mem_timeout;
  logic [7:0] outs;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(16), .WCNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ex_br_taken  (ex_br_taken),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .memwb_bubble (memwb_bubble),
    .mem_timeout  (mem_timeout)
`ifdef STALL_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_timeout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = 5'd0;
    ex_br_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #1 chk("reset_outs", {24'd0, outs}, {24'd0, C_RESET});
    tick();
    rst_n = 1'b1;
    #1 chk("normal_after_reset", {24'd0, outs}, {24'd0, C_NORMAL});
`ifdef STALL_STATS_EN
    chk("stats_reset", stall_cycles, 32'd0);
`endif

    // load-use on rs
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    #1 chk("lduse_rs", {24'd0, outs}, {24'd0, C_LDUSE});
    tick();
    idex_memread = 1'b0; idex_rt = 5'd0;
    #1 chk("lduse_rs_next", {24'd0, outs}, {24'd0, C_NORMAL});

    // load into $zero is not a hazard
    idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    #1 chk("lduse_zero", {24'd0, outs}, {24'd0, C_NORMAL});

    // load-use on rt, only when rt is a source
    idex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1 chk("lduse_rt", {24'd0, outs}, {24'd0, C_LDUSE});
    id_uses_rt = 1'b0;
    #1 chk("lduse_rt_unused", {24'd0, outs}, {24'd0, C_NORMAL});
    id_uses_rt = 1'b1;
    tick();
    clr();

    // branch, alone and over a load-use
    ex_br_taken = 1'b1;
    #1 chk("branch", {24'd0, outs}, {24'd0, C_BRANCH});
    idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4;
    #1 chk("branch_over_lduse", {24'd0, outs}, {24'd0, C_BRANCH});
    tick();
    clr();
    #1 chk("after_branch", {24'd0, outs}, {24'd0, C_NORMAL});

    // ready in the request cycle: no stall
    mem_req = 1'b1; dmem_ready = 1'b1;
    #1 chk("mem_ready_now", {24'd0, outs}, {24'd0, C_NORMAL});
    tick();

    // 3 wait cycles with a branch held by the frozen registers
    mem_req = 1'b1; dmem_ready = 1'b0; ex_br_taken = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 chk($sformatf("mem_wait_%0d", i), {24'd0, outs}, {24'd0, C_STALL});
      tick();
    end
    dmem_ready = 1'b1;
    #1 chk("mem_release_branch", {24'd0, outs}, {24'd0, C_BRANCH});
    tick();
    clr();
    #1 chk("after_release", {24'd0, outs}, {24'd0, C_NORMAL});
`ifdef STALL_STATS_EN
    chk("stats_count", stall_cycles, 32'd5);
`endif

    // timeout after 16 stalled cycles
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1 chk($sformatf("to_wait_%0d", i), {24'd0, outs}, {24'd0, C_STALL});
      tick();
    end
    #1 chk("timeout_entry", {24'd0, outs}, {24'd0, C_ERROR});
    tick();
    clr();
    #1 chk("timeout_sticky", {24'd0, outs}, {24'd0, C_ERROR});
    tick();
    rst_n = 1'b0;
    #1 chk("reset_in_error", {24'd0, outs}, {24'd0, C_RESET});
    tick();
    rst_n = 1'b1;
    #1 chk("idle_after_error_reset", {24'd0, outs}, {24'd0, C_NORMAL});
`ifdef STALL_STATS_EN
    chk("stats_after_reset", stall_cycles, 32'd0);
`endif

    // reset in the middle of a wait
    mem_req = 1'b1; dmem_ready = 1'b0;
    #1 chk("pre_reset_wait_1", {24'd0, outs}, {24'd0, C_STALL});
    tick();
    #1 chk("pre_reset_wait_2", {24'd0, outs}, {24'd0, C_STALL});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clr();
    #1 chk("idle_after_wait_reset", {24'd0, outs}, {24'd0, C_NORMAL});
`ifdef STALL_STATS_EN
    chk("stats_mid_wait_reset", stall_cycles, 32'd0);
`endif

    // a fresh access after reset stalls and releases normally
    mem_req = 1'b1; dmem_ready = 1'b0;
    #1 chk("fresh_wait", {24'd0, outs}, {24'd0, C_STALL});
    tick();
    dmem_ready = 1'b1;
    #1 chk("fresh_release", {24'd0, outs}, {24'd0, C_NORMAL});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions:
- load-use hazards, by inserting one bubble;
- taken branches, by flushing two stages;
- data-memory wait states, by freezing the whole pipeline with a request/ready handshake and a timeout.

## Interface
Parameters:
- MAX_WAIT, 16, max consecutive dmem wait cycles before timeout (≥1)
- WCNT_W, 5, wait counter width; must hold MAX_WAIT

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- idex_memread  in  1  MemRead of instruction in EX
- idex_rt  in  5  destination rt of instruction in EX
- ex_br_taken  in  1  branch/jump in EX resolved taken
- mem_req  in  1  instruction in MEM has MemRead or MemWrite
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC load enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX loads bubble (all controls 0)
- exmem_en  out  1  EX/MEM load enable
- memwb_bubble  out  1  MEM/WB loads RegWrite=0
- mem_timeout  out  1  sticky error flag

## Operation
- FSM states: IDLE, MEM_WAIT, ERROR. State is registered; all control outputs are combinational from state and inputs.
- Memory stall (highest priority):
  - Condition: mem_req=1 and dmem_ready=0, in IDLE or MEM_WAIT.
  - Outputs: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble=1; flushes are 0.
  - Transitions: IDLE goes to MEM_WAIT. In MEM_WAIT, dmem_ready=1 releases (normal outputs this cycle) and returns to IDLE.
- Branch: ex_br_taken=1 and not mem-stalled gives ifid_flush=1, idex_flush=1 and all enables 1. The PC loads the target.
- Load-use:
  - Condition: not mem-stalled, not branch, idex_memread=1, idex_rt≠0, and either idex_rt==id_rs or (id_uses_rt and idex_rt==id_rt).
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1.
- Normal: all enables 1, flushes 0, memwb_bubble=0.
- Wait counter:
  - Clears in IDLE and on release.
  - Increments on each MEM_WAIT cycle with dmem_ready=0.
  - When it reaches MAX_WAIT with dmem_ready still 0, the FSM goes to ERROR.
- ERROR: pipeline frozen (as a memory stall), mem_timeout=1. Left only by reset.

## Timing
- Zero-latency control: each hazard is acted on in the cycle it is detected.
- A load-use bubble lasts exactly 1 cycle. The condition clears itself once the load advances to MEM.
- A branch costs 2 flushed slots.
- A memory access with k wait cycles stalls exactly k cycles. The release cycle is the one with dmem_ready=1.
- Branch or load-use conditions present during a memory stall are held by the frozen registers and are acted on in the release cycle.
- Timeout: entry to ERROR happens at the edge after the MAX_WAIT-th stalled cycle of one access.
- Reset (rst_n=0 at the edge), including mid-MEM_WAIT or in ERROR: state becomes IDLE, counter 0, mem_timeout 0.
- While rst_n=0: pc_en=0, all stage enables 0, ifid_flush=1, idex_flush=1, memwb_bubble=1, mem_timeout=0.

## Configuration
- STALL_STATS_EN defined: adds output stall_cycles (32-bit, clk domain).
  - Counts every cycle with pc_en=0 while rst_n=1.
  - Reset value 0; wraps at 2^32.
- STALL_STATS_EN undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Package mips_pipe_pkg holds:
  - state enum (IDLE, MEM_WAIT, ERROR);
  - REG_ZERO constant (5'd0);
  - register-index typedef (5-bit).
- Sub-module: load_use_detect, combinational.
  - Inputs: id_rs, id_rt, id_uses_rt, idex_memread, idex_rt.
  - Output: hazard.
- The top level holds the FSM, wait counter, priority mux and optional stats counter.

## Test plan
- idex_memread=1, idex_rt=8, id_rs=8 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle normal.
- Same as above but idex_rt=0 → no stall.
- ex_br_taken=1 → ifid_flush=1, idex_flush=1, pc_en=1 for one cycle.
- mem_req=1, dmem_ready low for 3 cycles then high → exactly 3 cycles with all enables 0 and memwb_bubble=1; release on cycle 4. ex_br_taken held high throughout → flushes assert only on the release cycle.
- MAX_WAIT=16, dmem_ready held 0 → mem_timeout=1 after cycle 16 and stays high. rst_n=0 for 1 cycle → mem_timeout=0, state IDLE.
- STALL_STATS_EN defined → 1 load-use + 3 mem-wait stalls give stall_cycles=4. Reset mid-MEM_WAIT → stall_cycles=0.
